sync_gray_ptr: RTL and testbench

// - Destination-domain receiver for a Gray-coded FIFO pointer crossing from a foreign clock.
// - Generalised synchroniser: configurable stage count and pointer width.
// - Adds Gray->binary decode, per-update advance count, and change pulse.
// - Adds Gray-integrity checking: flag and count any multi-bit jump.
// - Sits in both the read-side and write-side domains of the async FIFO.

---
 rtl/sync_gray_ptr_pkg.sv | 30 +++
 rtl/sync_gray_ptr_if.sv | 40 ++++
 rtl/sync_gray_ptr_stages.sv | 46 ++++
 rtl/sync_gray_ptr.sv | 104 ++++++++++
 tb/tb_sync_gray_ptr.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_gray_ptr_pkg.sv
// Shared helpers for the Gray-pointer receiver: stage limits and the
// Gray decode / population count used by the decode and checker logic.
package sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int FUNC_W     = 32;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Narrower pointers are zero-extended by the caller, which leaves the result unchanged.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b[FUNC_W-1] = g[FUNC_W-1];
    for (int i = FUNC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits, used to detect Gray updates that moved more than one bit.
  function automatic int unsigned popcount(input logic [FUNC_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FUNC_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_gray_ptr_if.sv
// Pointer and status bundle between the foreign-domain pointer source
// and the destination-domain receiver. The master drives the Gray pointer
// and error clear; the slave (receiver) returns the decoded view.
interface sync_gray_ptr_if #(
  parameter int ADDR_W   = 4,
  parameter int ERRCNT_W = 8
);

  logic [ADDR_W:0]     i_grayPtr;
  logic                i_errClr;
  logic [ADDR_W:0]     o_syncGray;
  logic [ADDR_W:0]     o_syncBin;
  logic                o_changed;
  logic [ADDR_W:0]     o_advance;
  logic                o_grayErr;
  logic [ERRCNT_W-1:0] o_errCnt;

  modport master (
    output i_grayPtr,
    output i_errClr,
    input  o_syncGray,
    input  o_syncBin,
    input  o_changed,
    input  o_advance,
    input  o_grayErr,
    input  o_errCnt
  );

  modport slave (
    input  i_grayPtr,
    input  i_errClr,
    output o_syncGray,
    output o_syncBin,
    output o_changed,
    output o_advance,
    output o_grayErr,
    output o_errCnt
  );

endinterface

// File: rtl/sync_gray_ptr_stages.sv
// Pure multi-flop synchroniser chain for a Gray-coded bus. Nothing but
// flops lives here so the CDC boundary is easy to find and constrain.
module sync_stages
  import sync_pkg::*;
#(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Reject chain depths the timing closure was never planned for.
  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_badStages
    $error("sync_stages: STAGES=%0d outside legal range %0d..%0d",
           STAGES, MIN_STAGES, MAX_STAGES);
  end

  // The first flop samples an asynchronous bus and may go metastable;
  // this is intentional, so it is tagged as the CDC receive point.
  (* async_reg = "true", cdc_waiver = "gray_coded_bus_first_sync_flop" *)
  logic [W-1:0] meta_q;
  (* async_reg = "true" *)
  logic [W-1:0] chain_q [STAGES-1];

  // Shift the sampled pointer through the chain, one stage per edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        chain_q[k] <= '0;
      end
    end else begin
      meta_q     <= d_i;
      chain_q[0] <= meta_q;
      for (int k = 1; k < STAGES - 1; k++) begin
        chain_q[k] <= chain_q[k-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-2];

endmodule

// File: rtl/sync_gray_ptr.sv
// Destination-domain receiver for a Gray-coded FIFO pointer: synchronises
// the pointer, decodes it to binary, reports how far it moved since the
// last cycle, and flags any update that was not a clean single-bit step.
module sync_gray_ptr
  import sync_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int STAGES   = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic           i_clk,
  input  logic           i_arst,
  sync_gray_ptr_if.slave bus
);

  typedef logic [ADDR_W:0]     ptr_t;
  typedef logic [ERRCNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  ptr_t syncGray;
  ptr_t bin_d;
  ptr_t bin_q;
  ptr_t prev_q;
  ptr_t gprv_q;
  ptr_t grayHold_q;
  logic viol;
  logic errFlag_d;
  logic errFlag_q;
  cnt_t errCnt_d;
  cnt_t errCnt_q;

  sync_stages #(
    .W      (ADDR_W + 1),
    .STAGES (STAGES)
  ) u_stages (
    .clk_i (i_clk),
    .rst_i (i_arst),
    .d_i   (bus.i_grayPtr),
    .q_o   (syncGray)
  );

  // Binary form of the synchronised pointer, ready to be registered.
  always_comb begin
    bin_d = ptr_t'(gray2bin(FUNC_W'(syncGray)));
  end

  // Decode stage: current and previous binary value, plus two Gray samples
  // so the checker can compare consecutive synchronised updates.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      bin_q      <= '0;
      prev_q     <= '0;
      gprv_q     <= '0;
      grayHold_q <= '0;
    end else begin
      bin_q      <= bin_d;
      prev_q     <= bin_q;
      gprv_q     <= syncGray;
      grayHold_q <= gprv_q;
    end
  end

  // More than one bit changing between consecutive samples means the source
  // stepped faster than we sample, or the bus was not Gray-coded at all.
  assign viol = popcount(FUNC_W'(gprv_q ^ grayHold_q)) > 1;

  // Error bookkeeping: a fresh violation always wins over a clear so an
  // error arriving in the clear cycle is never lost.
  always_comb begin
    errFlag_d = errFlag_q;
    errCnt_d  = errCnt_q;
    if (viol) begin
      errFlag_d = 1'b1;
      if (bus.i_errClr) begin
        errCnt_d = cnt_t'(1);
      end else if (errCnt_q != CNT_MAX) begin
        errCnt_d = errCnt_q + cnt_t'(1);
      end
    end else if (bus.i_errClr) begin
      errFlag_d = 1'b0;
      errCnt_d  = '0;
    end
  end

  // Sticky error flag and saturating violation counter.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      errFlag_q <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      errFlag_q <= errFlag_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign bus.o_syncGray = syncGray;
  assign bus.o_syncBin  = bin_q;
  assign bus.o_changed  = (bin_q != prev_q);
  assign bus.o_advance  = bin_q - prev_q;
  assign bus.o_grayErr  = errFlag_q;
  assign bus.o_errCnt   = errCnt_q;

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Self-checking bench for sync_gray_ptr: directed Gray pointer steps with
// hand-computed expectations queued to a scoreboard, popped by a monitor
// whenever the receiver pulses o_changed.
module tb_sync_gray_ptr;

  localparam int ADDR_W   = 4;
  localparam int STAGES   = 3;
  localparam int ERRCNT_W = 2;

  typedef struct packed {
    logic [4:0] gray;
    logic [4:0] bin;
    logic [4:0] adv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t expQ[$];
  exp_t monExp;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [4:0] wrapGray [6] = '{5'h12, 5'h13, 5'h11, 5'h10, 5'h00, 5'h01};
  logic [4:0] wrapBin  [6] = '{5'd28, 5'd29, 5'd30, 5'd31, 5'd0, 5'd1};
  logic [4:0] violGray [4] = '{5'h04, 5'h0D, 5'h0E, 5'h0B};
  logic [4:0] violBin  [4] = '{5'd7, 5'd9, 5'd11, 5'd13};
  logic [1:0] violCnt  [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  sync_gray_ptr_if #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) bus ();

  sync_gray_ptr #(
    .ADDR_W   (ADDR_W),
    .STAGES   (STAGES),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .i_clk  (clk),
    .i_arst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " syncGray"}, 32'(bus.o_syncGray), 0);
    checkOutput({tag, " syncBin"},  32'(bus.o_syncBin),  0);
    checkOutput({tag, " changed"},  32'(bus.o_changed),  0);
    checkOutput({tag, " advance"},  32'(bus.o_advance),  0);
    checkOutput({tag, " grayErr"},  32'(bus.o_grayErr),  0);
    checkOutput({tag, " errCnt"},   32'(bus.o_errCnt),   0);
  endtask

  // Drive one pointer value just after an edge, optionally queue its expected
  // change pulse, then let the given number of edges pass.
  task automatic applyStimulus(input logic [4:0] g, input logic [4:0] b, input logic [4:0] adv,
                               input bit doPush, input int waitCycles);
    exp_t e;
    @(posedge clk);
    #2;
    bus.i_grayPtr = g;
    if (doPush) begin
      e.gray = g;
      e.bin  = b;
      e.adv  = adv;
      expQ.push_back(e);
    end
    repeat (waitCycles) @(posedge clk);
    #2;
  endtask

  // Monitor: every change pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_changed === 1'b1) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected change: actual syncBin=%0h advance=%0h required=no pulse",
                 bus.o_syncBin, bus.o_advance);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("mon syncGray", 32'(bus.o_syncGray), 32'(monExp.gray));
        checkOutput("mon syncBin",  32'(bus.o_syncBin),  32'(monExp.bin));
        checkOutput("mon advance",  32'(bus.o_advance),  32'(monExp.adv));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_grayPtr = '0;
    bus.i_errClr  = 1'b0;
    rst           = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("post-release syncBin", 32'(bus.o_syncBin), 0);

    // Latency: 0 -> 1, Gray visible after 3 edges, binary and pulse at edge 4
    @(posedge clk);
    #2;
    bus.i_grayPtr = 5'h01;
    expQ.push_back('{gray: 5'h01, bin: 5'h01, adv: 5'h01});
    @(posedge clk); #2;
    checkOutput("lat edge1 syncGray", 32'(bus.o_syncGray), 0);
    @(posedge clk); #2;
    checkOutput("lat edge2 syncGray", 32'(bus.o_syncGray), 0);
    @(posedge clk); #2;
    checkOutput("lat edge3 syncGray", 32'(bus.o_syncGray), 1);
    checkOutput("lat edge3 syncBin",  32'(bus.o_syncBin),  0);
    @(posedge clk); #2;
    checkOutput("lat edge4 syncBin",  32'(bus.o_syncBin),  1);
    checkOutput("lat edge4 changed",  32'(bus.o_changed),  1);
    checkOutput("lat edge4 advance",  32'(bus.o_advance),  1);
    @(posedge clk); #2;
    checkOutput("lat edge5 changed",  32'(bus.o_changed),  0);
    checkOutput("lat edge5 advance",  32'(bus.o_advance),  0);

    // Legal single steps up to 27, then the wrap 28..31,0,1
    for (int b = 2; b <= 27; b++) begin
      applyStimulus(toGray(5'(b)), 5'(b), 5'd1, 1'b1, 3);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(wrapGray[i], wrapBin[i], 5'd1, 1'b1, 3);
    end
    repeat (4) @(posedge clk);
    #2;
    checkOutput("wrap syncBin",  32'(bus.o_syncBin), 1);
    checkOutput("wrap grayErr",  32'(bus.o_grayErr), 0);
    checkOutput("wrap errCnt",   32'(bus.o_errCnt),  0);

    // Multi-step jump gray(3) -> gray(5)
    applyStimulus(5'h03, 5'd2, 5'd1, 1'b1, 3);
    applyStimulus(5'h02, 5'd3, 5'd1, 1'b1, 6);
    checkOutput("pre-jump grayErr", 32'(bus.o_grayErr), 0);
    applyStimulus(5'h07, 5'd5, 5'd2, 1'b1, 6);
    checkOutput("jump syncBin", 32'(bus.o_syncBin), 5);
    checkOutput("jump grayErr", 32'(bus.o_grayErr), 1);
    checkOutput("jump errCnt",  32'(bus.o_errCnt),  1);

    // Four more violations: 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(violGray[i], violBin[i], 5'd2, 1'b1, 6);
      checkOutput("sat errCnt",  32'(bus.o_errCnt),  32'(violCnt[i]));
      checkOutput("sat grayErr", 32'(bus.o_grayErr), 1);
    end
    @(posedge clk); #2;
    bus.i_errClr = 1'b1;
    @(posedge clk); #2;
    bus.i_errClr = 1'b0;
    checkOutput("clear grayErr", 32'(bus.o_grayErr), 0);
    checkOutput("clear errCnt",  32'(bus.o_errCnt),  0);

    // Collision: counter at 1, then clear lands on the next violation's cycle
    applyStimulus(5'h08, 5'd15, 5'd2, 1'b1, 6);
    checkOutput("pre-collision errCnt", 32'(bus.o_errCnt), 1);
    @(posedge clk); #2;
    bus.i_grayPtr = 5'h19;
    expQ.push_back('{gray: 5'h19, bin: 5'd17, adv: 5'd2});
    repeat (4) @(posedge clk);
    #2;
    bus.i_errClr = 1'b1;
    @(posedge clk); #2;
    bus.i_errClr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("collision grayErr", 32'(bus.o_grayErr), 1);
    checkOutput("collision errCnt",  32'(bus.o_errCnt),  1);

    // Async reset between edges with an update still in the chain
    @(posedge clk); #2;
    bus.i_grayPtr = 5'h1B;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.i_grayPtr = 5'h00;
    #1;
    checkAllZero("async");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("post-reset syncBin",  32'(bus.o_syncBin),  0);
    checkOutput("post-reset syncGray", 32'(bus.o_syncGray), 0);
    applyStimulus(5'h01, 5'd1, 5'd1, 1'b1, 6);
    checkOutput("post-reset step syncBin", 32'(bus.o_syncBin), 1);
    checkOutput("post-reset step grayErr", 32'(bus.o_grayErr), 0);
    checkOutput("post-reset step errCnt",  32'(bus.o_errCnt),  0);

    // Every queued pulse must have been seen
    repeat (2) @(posedge clk);
    #2;
    checkOutput("scoreboard drained", 32'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
